peripheral_mpi_ahb3_bridge: RTL and testbench

//  AHB-Lite (AMBA3) slave that converts pipelined AHB transfers into the generic single-access bus
//  (bus_addr/we/en/data_in -> data_out/ack/err) consumed by peripheral_mpi_buffer.

---
 rtl/peripheral_mpi_pkg.sv | 28 ++
 rtl/peripheral_mpi_ahb3_bridge.sv | 152 +++++++++++++++
 tb/tb_peripheral_mpi_ahb3_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_mpi_pkg.sv
`default_nettype none
// ============================================================================
// Module : peripheral_mpi_pkg
// Brief  : Shared FSM states and AHB3 encodings for the MPI AHB3 bridge.
// Rev    : 1.0
// ============================================================================
package peripheral_mpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_DONE   = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/peripheral_mpi_ahb3_bridge.sv
`default_nettype none
// ============================================================================
// Module : peripheral_mpi_ahb3_bridge
// Brief  : AHB3-Lite slave to generic single-access bus; one access in flight.
//          Optional access timeout enabled by MPI_AHB3_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module peripheral_mpi_ahb3_bridge
  import peripheral_mpi_pkg::*;
#(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb3_hsel,
  input  logic [PLEN-1:0] ahb3_haddr,
  input  logic [XLEN-1:0] ahb3_hwdata,
  input  logic            ahb3_hwrite,
  input  logic [2:0]      ahb3_hsize,
  input  logic [1:0]      ahb3_htrans,
  input  logic            ahb3_hready,
  output logic [XLEN-1:0] ahb3_hrdata,
  output logic            ahb3_hreadyout,
  output logic            ahb3_hresp,
  output logic [31:0]     bus_addr,
  output logic            bus_we,
  output logic            bus_en,
  output logic [31:0]     bus_data_in,
  input  logic [31:0]     bus_data_out,
  input  logic            bus_ack,
  input  logic            bus_err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        we_q, we_d;

  logic [31:0] haddr32;
  logic        hreadyout;
  logic        accept;
  logic        legal;
  logic        timeout_hit;
  logic        unused_ok;

  generate
    if (PLEN >= 32) begin : g_addr_trunc
      assign haddr32 = ahb3_haddr[31:0];
      if (PLEN > 32) begin : g_addr_high
        logic unused_haddr_high;
        assign unused_haddr_high = ^ahb3_haddr[PLEN-1:32];
      end
    end else begin : g_addr_ext
      assign haddr32 = {{(32-PLEN){1'b0}}, ahb3_haddr};
    end
  endgenerate

  // Only NONSEQ/SEQ start an access; bit 0 separates IDLE from BUSY.
  assign unused_ok = ahb3_htrans[0];

  assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept    = ahb3_hsel && ahb3_hready && ahb3_htrans[1] && hreadyout;
  assign legal     = (ahb3_hsize == HSIZE_WORD) && (haddr32[1:0] == 2'b00);

`ifdef MPI_AHB3_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !bus_ack && !bus_err) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_ACCESS) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    hrdata_d = hrdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = haddr32;
          we_d    = ahb3_hwrite;
          state_d = legal ? ST_ACCESS : ST_ERR1;
        end
      end
      ST_ACCESS: begin
        // Error has priority over a simultaneous ack; an ack beats the timeout.
        if (bus_err) begin
          state_d = ST_ERR1;
        end else if (bus_ack) begin
          state_d = ST_DONE;
          if (!we_q) begin
            hrdata_d = bus_data_out;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign ahb3_hreadyout = hreadyout;
  assign ahb3_hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign ahb3_hrdata    = hrdata_q;
  assign bus_en         = (state_q == ST_ACCESS);
  assign bus_we         = bus_en && we_q;
  assign bus_addr       = addr_q;
  assign bus_data_in    = ahb3_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mpi_ahb3_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_peripheral_mpi_ahb3_bridge
// Brief  : Random AHB3 traffic against a queue-based reference and bus slave.
// Rev    : 1.0
// ============================================================================
module tb_peripheral_mpi_ahb3_bridge;

  logic        clk;
  logic        rst;
  logic        ahb3_hsel;
  logic [31:0] ahb3_haddr;
  logic [31:0] ahb3_hwdata;
  logic        ahb3_hwrite;
  logic [2:0]  ahb3_hsize;
  logic [1:0]  ahb3_htrans;
  logic        ahb3_hready;
  logic [31:0] ahb3_hrdata;
  logic        ahb3_hreadyout;
  logic        ahb3_hresp;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_en;
  logic [31:0] bus_data_in;
  logic [31:0] bus_data_out;
  logic        bus_ack;
  logic        bus_err;

  assign ahb3_hready = ahb3_hreadyout;

  peripheral_mpi_ahb3_bridge #(.PLEN(32), .XLEN(32), .TIMEOUT(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .ahb3_hsel      (ahb3_hsel),
    .ahb3_haddr     (ahb3_haddr),
    .ahb3_hwdata    (ahb3_hwdata),
    .ahb3_hwrite    (ahb3_hwrite),
    .ahb3_hsize     (ahb3_hsize),
    .ahb3_htrans    (ahb3_htrans),
    .ahb3_hready    (ahb3_hready),
    .ahb3_hrdata    (ahb3_hrdata),
    .ahb3_hreadyout (ahb3_hreadyout),
    .ahb3_hresp     (ahb3_hresp),
    .bus_addr       (bus_addr),
    .bus_we         (bus_we),
    .bus_en         (bus_en),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .bus_ack        (bus_ack),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          stalls;
    logic        err;
  } txn_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  txn_t stim_q[$];
  txn_t rsp_q[$];
  exp_t exp_q[$];

  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] last_rd;

  int  n_checks;
  int  n_errors;
  bit  mon_en;
  bit  hold;
  logic [31:0] ap_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten slave locations read back as address ^ 1.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h1;
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                              input logic [31:0] d, input int st, input logic e);
    txn_t t;
    t.addr = a; t.we = w; t.size = s; t.wdata = d; t.stalls = st; t.err = e;
    return t;
  endfunction

  task automatic present(input txn_t t);
    exp_t e;
    ahb3_hsel   = 1'b1;
    ahb3_htrans = $urandom_range(0, 1) ? 2'b11 : 2'b10;
    ahb3_haddr  = t.addr;
    ahb3_hwrite = t.we;
    ahb3_hsize  = t.size;
    ap_wdata    = t.wdata;
    if ((t.size != 3'b010) || (t.addr[1:0] != 2'b00)) begin
      e.err   = 1'b1;
      e.waits = 1;
    end else begin
      rsp_q.push_back(t);
      e.err   = t.err;
      e.waits = t.err ? t.stalls + 2 : t.stalls + 1;
      if (!t.err) begin
        if (t.we) model_mem[t.addr] = t.wdata;
        else      last_rd = model_mem.exists(t.addr) ? model_mem[t.addr] : dflt(t.addr);
      end
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
  endtask

  task automatic drive_noise();
    case ($urandom_range(0, 2))
      0:       begin ahb3_hsel = 1'b1; ahb3_htrans = 2'b00; end
      1:       begin ahb3_hsel = 1'b1; ahb3_htrans = 2'b01; end
      default: begin ahb3_hsel = 1'b0; ahb3_htrans = 2'b10; end
    endcase
    ahb3_haddr  = $urandom;
    ahb3_hwrite = 1'($urandom_range(0, 1));
    ahb3_hsize  = 3'b010;
    ap_wdata    = $urandom;
  endtask

  // Bus slave: checks each generic access and responds after the planned stalls.
  initial begin
    int   r_cnt;
    bit   r_act;
    bit   last_done;
    txn_t cur;
    bus_ack = 1'b0; bus_err = 1'b0; bus_data_out = 32'h0;
    r_cnt = 0; r_act = 0; last_done = 0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (rst || hold) begin
        r_act = 0;
        last_done = 0;
      end else if (bus_en) begin
        chk("bus_en_after_resp", 32'(last_done), 32'h0);
        last_done = 0;
        if (!r_act) begin
          chk("bus_en_expected", 32'(rsp_q.size() > 0), 32'h1);
          if (rsp_q.size() > 0) begin
            cur = rsp_q.pop_front();
            r_act = 1;
            r_cnt = 0;
          end
        end
        if (r_act) begin
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_we", 32'(bus_we), 32'(cur.we));
          if (cur.we) chk("bus_data_in", bus_data_in, cur.wdata);
          if (r_cnt == cur.stalls) begin
            if (cur.err) begin
              bus_err = 1'b1;
              bus_ack = 1'($urandom_range(0, 1));
              bus_data_out = $urandom;
            end else begin
              bus_ack = 1'b1;
              if (cur.we) slave_mem[bus_addr] = bus_data_in;
              else bus_data_out = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : dflt(bus_addr);
            end
            r_act = 0;
            last_done = 1;
          end else begin
            r_cnt++;
            bus_data_out = $urandom;
          end
        end
      end else begin
        last_done = 0;
      end
    end
  end

  // AHB monitor: pairs each completed data phase with the oldest expected response.
  initial begin
    bit   dp_act;
    bit   idle_dp;
    int   waits;
    logic lo_resp;
    exp_t e;
    dp_act = 0; idle_dp = 0; waits = 0; lo_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        dp_act = 0;
        idle_dp = 0;
      end else begin
        if (dp_act) begin
          if (!ahb3_hreadyout) begin
            waits++;
            lo_resp = ahb3_hresp;
          end else begin
            chk("resp_expected", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("hresp", 32'(ahb3_hresp), 32'(e.err));
              chk("wait_cycles", 32'(waits), 32'(e.waits));
              chk("hrdata", ahb3_hrdata, e.rdata);
              if (waits > 0) chk("hresp_wait_phase", 32'(lo_resp), 32'(e.err));
            end
            dp_act = 0;
          end
        end else if (idle_dp) begin
          chk("idle_zero_wait", 32'(ahb3_hreadyout), 32'h1);
          chk("idle_okay", 32'(ahb3_hresp), 32'h0);
          idle_dp = 0;
        end
        if (ahb3_hreadyout && !dp_act) begin
          if (ahb3_hsel && ahb3_htrans[1]) begin
            dp_act = 1; waits = 0; lo_resp = 1'b0;
          end else begin
            idle_dp = 1;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hr_edge;
    int i;
    int n_dir;
    n_checks = 0; n_errors = 0; mon_en = 0; hold = 0; last_rd = 32'h0;
    rst = 1'b1;
    ahb3_hsel = 1'b0; ahb3_haddr = 32'h0; ahb3_hwdata = 32'h0; ahb3_hwrite = 1'b0;
    ahb3_hsize = 3'b010; ahb3_htrans = 2'b00; ap_wdata = 32'h0;

    stim_q.push_back(mk(32'h0000_0000, 1'b0, 3'b010, 32'h0, 0, 1'b0));
    stim_q.push_back(mk(32'h0000_2000, 1'b1, 3'b010, 32'hDEAD_BEEF, 3, 1'b0));
    stim_q.push_back(mk(32'h0000_0000, 1'b0, 3'b010, 32'h0, 0, 1'b0));
    stim_q.push_back(mk(32'h0000_2000, 1'b0, 3'b010, 32'h0, 0, 1'b0));
    stim_q.push_back(mk(32'h0000_0040, 1'b0, 3'b000, 32'h0, 0, 1'b0));
    stim_q.push_back(mk(32'h0000_0002, 1'b0, 3'b010, 32'h0, 0, 1'b0));
    stim_q.push_back(mk(32'h0000_0000, 1'b1, 3'b010, 32'h1234_5678, 1, 1'b1));
    n_dir = stim_q.size();
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      logic [2:0]  s;
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      stim_q.push_back(mk(a, 1'($urandom_range(0, 1)), s, $urandom,
                          int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0)));
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hreadyout", 32'(ahb3_hreadyout), 32'h1);
    chk("rst_hresp", 32'(ahb3_hresp), 32'h0);
    chk("rst_hrdata", ahb3_hrdata, 32'h0);
    chk("rst_bus_en", 32'(bus_en), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    mon_en = 1;
    hr_edge = ahb3_hreadyout;

    i = 0;
    while (i < stim_q.size()) begin
      @(posedge clk); #1;
      if (hr_edge) begin
        ahb3_hwdata = ap_wdata;
        if ((i < n_dir) || ($urandom_range(0, 9) < 7)) begin
          present(stim_q[i]);
          i++;
        end else begin
          drive_noise();
        end
      end
      hr_edge = ahb3_hreadyout;
    end
    for (int c = 0; (c < 3000) && (exp_q.size() > 0); c++) begin
      @(posedge clk); #1;
      if (hr_edge) begin
        ahb3_hwdata = ap_wdata;
        drive_noise();
      end
      hr_edge = ahb3_hreadyout;
    end
    repeat (3) @(posedge clk);
    chk("drain_complete", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of a stalled access discards it without a response.
    mon_en = 0;
    hold = 1;
    @(posedge clk); #1;
    ahb3_hsel = 1'b1; ahb3_htrans = 2'b10; ahb3_haddr = 32'h40;
    ahb3_hwrite = 1'b0; ahb3_hsize = 3'b010;
    @(posedge clk); #1;
    ahb3_hsel = 1'b0; ahb3_htrans = 2'b00;
    chk("rst_test_access", 32'(bus_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_bus_en", 32'(bus_en), 32'h0);
    chk("midrst_hreadyout", 32'(ahb3_hreadyout), 32'h1);
    chk("midrst_hresp", 32'(ahb3_hresp), 32'h0);
    chk("midrst_bus_addr", bus_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
